// File: rtl/present80_pkg.sv
// PRESENT-80 constants, FSM state type and the cipher primitive functions.
package present80_pkg;

    localparam int PRESENT80_ROUNDS = 31;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [63:0] sbox64(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 16; i++) o[4*i +: 4] = sbox4(x[4*i +: 4]);
        return o;
    endfunction

    // bit i moves to i*16 mod 63; bit 63 stays in place
    function automatic logic [63:0] player64(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 63; i++) o[(i*16) % 63] = x[i];
        o[63] = x[63];
        return o;
    endfunction

    // rotate left 61, S-box the top nibble, fold the round counter into [19:15]
    function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = sbox4(t[79:76]);
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction

endpackage

// File: rtl/present80_round.sv
// One PRESENT round: add round key, S-box layer, bit permutation.
module present80_round
    import present80_pkg::*;
(
    input  logic [63:0] in,
    input  logic [63:0] rkey,
    output logic [63:0] out
);

    assign out = player64(sbox64(in ^ rkey));

endmodule

// File: rtl/present80_seq_ctrl.sv
// Iterative PRESENT-80 encryptor with valid/ready in and out; one block in flight.
module present80_seq_ctrl
    import present80_pkg::*;
#(
    parameter int NUM_ROUNDS = PRESENT80_ROUNDS
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [79:0] key,
    input  logic [63:0] plaintext,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] ciphertext,
    output logic        busy
);

    localparam logic [4:0] LAST_ROUND = NUM_ROUNDS[4:0];

    state_t      state, state_nxt;
    logic [63:0] state_reg;
    logic [79:0] key_reg;
    logic [4:0]  round_cnt;
    logic [63:0] round_out;

    present80_round u_round (
        .in   (state_reg),
        .rkey (key_reg[79:16]),
        .out  (round_out)
    );

    // status outputs decode the state only, so no input reaches them combinationally
    assign in_ready = (state == IDLE);
    assign busy     = (state == RUN) || (state == FINAL);

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (round_cnt == LAST_ROUND) state_nxt = FINAL;
            FINAL:   state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cipher state, key schedule, round counter and result registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= '0;
            key_reg    <= '0;
            round_cnt  <= '0;
            ciphertext <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= plaintext;
                        key_reg   <= key;
                        round_cnt <= 5'd1;
                    end
                end
                RUN: begin
                    state_reg <= round_out;
                    key_reg   <= key_update(key_reg, round_cnt);
                    // counter parks on the last round instead of wrapping
                    if (round_cnt != LAST_ROUND) round_cnt <= round_cnt + 5'd1;
                end
                FINAL: begin
                    ciphertext <= state_reg ^ key_reg[79:16];
                    out_valid  <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_present80_seq_ctrl.sv
// Known-answer, backpressure, back-to-back and reset tests with a ciphertext scoreboard.
module tb_present80_seq_ctrl;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [79:0] key;
    logic [63:0] plaintext;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ciphertext;
    logic        busy;

    present80_seq_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key        (key),
        .plaintext  (plaintext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    typedef struct {
        logic [79:0] k;
        logic [63:0] pt;
        logic [63:0] ct;
    } kat_t;

    typedef struct {
        logic [63:0] ct;
        int          acc;
    } exp_t;

    kat_t kat [4];
    exp_t sb [$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_ov = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] lookup(input logic [79:0] k, input logic [63:0] pt);
        for (int i = 0; i < 4; i++)
            if (kat[i].k == k && kat[i].pt == pt) return kat[i].ct;
        return 64'h0;
    endfunction

    // scoreboard: push on input handshake, check latency on out_valid rise, pop on output handshake
    always @(negedge clk) begin
        if (rstn) begin
            if (in_valid && in_ready) sb.push_back('{lookup(key, plaintext), cyc + 1});
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
                else chk("latency", 64'(cyc - sb[0].acc), 64'd32);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("spurious_handshake", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ciphertext", ciphertext, e.ct);
                end
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    task automatic wait_acc();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 80);
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send(input int i);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        key       = kat[i].k;
        plaintext = kat[i].pt;
        wait_acc();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 80);
        if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 64'(sb.size()), 64'd0);
    endtask

    int          acc [4];
    logic [63:0] held;

    initial begin
        kat[0] = '{80'h0,                    64'h0,                 64'h5579C1387B228445};
        kat[1] = '{80'hFFFFFFFFFFFFFFFFFFFF, 64'h0,                 64'hE72C46C0F5945049};
        kat[2] = '{80'h0,                    64'hFFFFFFFFFFFFFFFF,  64'hA112FFC72F68417B};
        kat[3] = '{80'hFFFFFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,  64'h3333DCD3213210D2};

        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; key = '0; plaintext = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",   64'(in_ready),  64'd1);
        chk("rst_out_valid",  64'(out_valid), 64'd0);
        chk("rst_busy",       64'(busy),      64'd0);
        chk("rst_ciphertext", ciphertext,     64'h0);
        @(posedge clk); #1 rstn = 1'b1;

        // known-answer table, out_ready high
        for (int i = 0; i < 4; i++) begin
            send(i);
            @(negedge clk);
            chk("busy_in_run",     64'(busy),     64'd1);
            chk("in_ready_in_run", 64'(in_ready), 64'd0);
            drain();
        end

        // backpressure: result held for 20 cycles
        out_ready = 1'b0;
        send(0);
        wait_ov();
        held = ciphertext;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || ciphertext !== held || in_ready !== 1'b0) begin
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                chk("bp_stable",    ciphertext,     held);
                chk("bp_in_ready",  64'(in_ready),  64'd0);
            end else n_vec++;
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready",  64'(in_ready),  64'd1);
        chk("bp_idle_out_valid", 64'(out_valid), 64'd0);

        // input pulses during RUN are ignored
        send(0);
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b1; key = kat[3].k; plaintext = kat[3].pt;
        @(negedge clk);
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        chk("no_second_output", 64'(out_valid), 64'd0);

        // back-to-back with in_valid held high
        @(posedge clk); #1;
        in_valid = 1'b1; key = kat[0].k; plaintext = kat[0].pt;
        for (int i = 0; i < 4; i++) begin
            wait_acc();
            acc[i] = cyc + 1;
            @(posedge clk); #1;
            if (i < 3) begin
                key = kat[i+1].k; plaintext = kat[i+1].pt;
            end else in_valid = 1'b0;
        end
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 64'(acc[i] - acc[i-1]), 64'd34);
        drain();

        // reset mid-run discards the block
        send(1);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_run_out_valid",  64'(out_valid), 64'd0);
        chk("rst_run_ciphertext", ciphertext,     64'h0);
        chk("rst_run_in_ready",   64'(in_ready),  64'd1);
        chk("rst_run_busy",       64'(busy),      64'd0);
        sb.delete();
        @(posedge clk); #1 rstn = 1'b1;
        send(2);
        drain();

        // reset while holding a result in DONE
        out_ready = 1'b0;
        send(3);
        wait_ov();
        rstn = 1'b0;
        #1;
        chk("rst_done_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk); #1 rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_in_ready",  64'(in_ready),  64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
